// File: rtl/gray_count_rx_pkg.sv
// Shared types and helpers for the gray-count receiver.
package gray_count_rx_pkg;

    localparam int unsigned GCR_MAX_WIDTH = 32;

    typedef enum logic {
        PRIME,
        TRACK
    } gcr_state_e;

    // Bit i of the result is the XOR of g[MSB:i]; unused upper bits are zero.
    function automatic logic [GCR_MAX_WIDTH-1:0] gray2bin(input logic [GCR_MAX_WIDTH-1:0] g);
        logic [GCR_MAX_WIDTH-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < GCR_MAX_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_count_rx_sync.sv
// Multi-flop synchronizer chain for an asynchronous bus.
module gray_count_rx_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the sampled bus through STAGES flops; reset clears every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_count_rx.sv
// Destination-side receiver for a gray-coded count: synchronize, decode,
// accumulate increments and hand them off over valid/ready.
// Optional step checker (MAX_STEP parameter, err_d port) is built when
// GRAY_COUNT_RX_STEP_CHK_EN is defined.
module gray_count_rx
    import gray_count_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OFFSET      = 0
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
    ,
    parameter int unsigned MAX_STEP    = 1
`endif
) (
    input  logic             clk_d,
    input  logic             rst_d_n,
    input  logic             init_d_n,
    input  logic [WIDTH-1:0] gray_s,
    output logic [WIDTH-1:0] count_d,
    output logic [WIDTH:0]   delta_d,
    output logic             delta_vld_d,
    input  logic             delta_rdy_d,
    output logic             ovf_d
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
    ,
    output logic             err_d
`endif
);

    localparam logic [WIDTH-1:0] OFF       = WIDTH'(OFFSET);
    localparam logic [2:0]       FILL_LAST = 3'(SYNC_STAGES);

    logic             clr_n;
    logic [WIDTH-1:0] g_sync;
    logic [WIDTH-1:0] bin_new;

    gcr_state_e       state_q, state_nx;
    logic [2:0]       fill_q, fill_nx;
    logic [WIDTH-1:0] bin_q, bin_nx;
    logic [WIDTH-1:0] count_q, count_nx;
    logic [WIDTH:0]   pend_q, pend_nx;
    logic             ovf_q, ovf_nx;
    logic [WIDTH-1:0] inc;
    logic             hs;
    logic [WIDTH:0]   base;
    logic [WIDTH+1:0] sum;

    // Reset and functional init have identical effect, including on the synchronizer.
    assign clr_n = rst_d_n & init_d_n;

    gray_count_rx_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_d),
        .rst_n (clr_n),
        .d     (gray_s),
        .q     (g_sync)
    );

    assign bin_new = WIDTH'(gray2bin(GCR_MAX_WIDTH'(g_sync)));

    // Next state: wait out the synchronizer fill, load a baseline, then track.
    always_comb begin
        state_nx = state_q;
        fill_nx  = fill_q;
        bin_nx   = bin_q;
        count_nx = count_q;
        inc      = '0;
        case (state_q)
            PRIME: begin
                if (fill_q == FILL_LAST) begin
                    bin_nx   = bin_new;
                    count_nx = bin_new - OFF;
                    state_nx = TRACK;
                end else begin
                    fill_nx = fill_q + 3'd1;
                end
            end
            TRACK: begin
                inc      = bin_new - bin_q;
                bin_nx   = bin_new;
                count_nx = bin_new - OFF;
            end
        endcase
    end

    // Accumulator: a handshake restarts from this cycle's increment so nothing
    // arriving on the same edge is dropped; the carry bit flags saturation.
    always_comb begin
        hs      = delta_vld_d && delta_rdy_d;
        base    = hs ? '0 : pend_q;
        sum     = {1'b0, base} + {2'b00, inc};
        pend_nx = sum[WIDTH:0];
        ovf_nx  = ovf_q;
        if (sum[WIDTH+1]) begin
            pend_nx = '1;
            ovf_nx  = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_d) begin
        if (!rst_d_n || !init_d_n) begin
            state_q <= PRIME;
            fill_q  <= '0;
            bin_q   <= '0;
            count_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            fill_q  <= fill_nx;
            bin_q   <= bin_nx;
            count_q <= count_nx;
            pend_q  <= pend_nx;
            ovf_q   <= ovf_nx;
        end
    end

    assign count_d     = count_q;
    assign delta_d     = pend_q;
    assign delta_vld_d = (pend_q != '0);
    assign ovf_d       = ovf_q;

`ifdef GRAY_COUNT_RX_STEP_CHK_EN
    logic [WIDTH-1:0] g_prev_q;
    logic [WIDTH-1:0] g_diff;
    logic             step_bad;
    logic             err_q;

    // Flag an oversized decoded step or a multi-bit change in the sampled gray word.
    always_comb begin
        g_diff   = g_sync ^ g_prev_q;
        step_bad = (32'(inc) > 32'(MAX_STEP)) || ((g_diff & (g_diff - 1'b1)) != '0);
    end

    // Previous synchronized sample and sticky error flag.
    always_ff @(posedge clk_d) begin
        if (!rst_d_n || !init_d_n) begin
            g_prev_q <= '0;
            err_q    <= 1'b0;
        end else begin
            g_prev_q <= g_sync;
            if (state_q == TRACK && step_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_d = err_q;
`endif

endmodule

// File: tb/tb_gray_count_rx.sv
// Scoreboard bench for gray_count_rx: stimulus pushes expected outputs from a
// history-based reference model; a monitor pops and compares every cycle.
// err_d is checked when GRAY_COUNT_RX_STEP_CHK_EN is defined.
module tb_gray_count_rx;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int OFF = 5;
    localparam int MAX_STEP = 1;
    localparam int SAT = (1 << (W + 1)) - 1;

    logic         clk_d = 1'b0;
    logic         rst_d_n = 1'b0;
    logic         init_d_n = 1'b1;
    logic [W-1:0] gray_s = '0;
    logic [W-1:0] count_d;
    logic [W:0]   delta_d;
    logic         delta_vld_d;
    logic         delta_rdy_d = 1'b0;
    logic         ovf_d;
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
    logic         err_d;
`endif

    gray_count_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .OFFSET      (OFF)
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
        ,
        .MAX_STEP    (MAX_STEP)
`endif
    ) dut (
        .clk_d       (clk_d),
        .rst_d_n     (rst_d_n),
        .init_d_n    (init_d_n),
        .gray_s      (gray_s),
        .count_d     (count_d),
        .delta_d     (delta_d),
        .delta_vld_d (delta_vld_d),
        .delta_rdy_d (delta_rdy_d),
        .ovf_d       (ovf_d)
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
        ,
        .err_d       (err_d)
`endif
    );

    always #5 clk_d = ~clk_d;

    typedef struct {
        int   cyc;
        logic [W-1:0] count;
        logic [W:0]   delta;
        logic vld;
        logic ovf;
        logic err;
    } exp_t;

    exp_t expq[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state: gray history since the last reset/init release.
    logic [W-1:0] hist[$];
    int           n = 0;
    int           m_pend = 0;
    logic         m_ovf = 1'b0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_bin = '0;
    logic [W-1:0] m_count = '0;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input logic rst, input logic init, input logic [W-1:0] g, input logic rdy);
        exp_t e;
        logic hs;
        logic [W-1:0] gs, gp, b, inc;
        int sum;
        @(negedge clk_d);
        rst_d_n = rst;
        init_d_n = init;
        gray_s = g;
        delta_rdy_d = rdy;
        cyc++;
        if (!rst || !init) begin
            hist.delete();
            n = 0;
            m_pend = 0;
            m_ovf = 1'b0;
            m_err = 1'b0;
            m_bin = '0;
            m_count = '0;
        end else begin
            hs = (m_pend != 0) && rdy;
            hist.push_back(g);
            n++;
            inc = '0;
            // Sampled value seen at edge n is the input present before edge n-S.
            if (n > S) begin
                gs = hist[n-S-1];
                b = from_gray(gs);
                if (n > S + 1) begin
                    inc = b - m_bin;
                    gp = hist[n-S-2];
                    if (int'(inc) > MAX_STEP || $countones(gs ^ gp) > 1) m_err = 1'b1;
                end
                m_bin = b;
                m_count = b - W'(OFF);
            end
            sum = (hs ? 0 : m_pend) + int'(inc);
            if (sum > SAT) begin
                m_pend = SAT;
                m_ovf = 1'b1;
            end else begin
                m_pend = sum;
            end
        end
        e.cyc = cyc;
        e.count = m_count;
        e.delta = (W+1)'(m_pend);
        e.vld = (m_pend != 0);
        e.ovf = m_ovf;
        e.err = m_err;
        expq.push_back(e);
    endtask

    task automatic hold(input int cycles, input logic [W-1:0] g, input logic rdy);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, g, rdy);
    endtask

    // Monitor: compare DUT outputs just after each active edge.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk_d);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                vectors++;
                bad = (count_d !== e.count) || (delta_d !== e.delta) ||
                      (delta_vld_d !== e.vld) || (ovf_d !== e.ovf);
`ifdef GRAY_COUNT_RX_STEP_CHK_EN
                bad = bad || (err_d !== e.err);
                if (bad) $display("FAIL outputs cyc%0d: got count=%0d delta=%0d vld=%b ovf=%b err=%b, want count=%0d delta=%0d vld=%b ovf=%b err=%b",
                                  e.cyc, count_d, delta_d, delta_vld_d, ovf_d, err_d, e.count, e.delta, e.vld, e.ovf, e.err);
`else
                if (bad) $display("FAIL outputs cyc%0d: got count=%0d delta=%0d vld=%b ovf=%b, want count=%0d delta=%0d vld=%b ovf=%b",
                                  e.cyc, count_d, delta_d, delta_vld_d, ovf_d, e.count, e.delta, e.vld, e.ovf);
`endif
                if (bad) miscompares++;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [W-1:0] cnt;
        logic rst, init, rdy;
        logic [W-1:0] g;

        // Reset with bin 8 held: baseline loads without generating a delta.
        step(1'b0, 1'b1, to_gray(8'd8), 1'b0);
        step(1'b0, 1'b1, to_gray(8'd8), 1'b0);
        hold(6, to_gray(8'd8), 1'b0);

        // 8 -> 12 one step per 4 cycles, no consumer, then one accept.
        for (int b = 9; b <= 12; b++) hold(4, to_gray(W'(b)), 1'b0);
        hold(4, to_gray(8'd12), 1'b0);
        hold(1, to_gray(8'd12), 1'b1);
        hold(2, to_gray(8'd12), 1'b0);

        // Wrap across 255 -> 0: drain the big jump first, then 254..1.
        hold(5, to_gray(8'd254), 1'b0);
        hold(1, to_gray(8'd254), 1'b1);
        hold(1, to_gray(8'd254), 1'b0);
        hold(4, to_gray(8'd255), 1'b0);
        hold(4, to_gray(8'd0), 1'b0);
        hold(4, to_gray(8'd1), 1'b0);
        hold(4, to_gray(8'd1), 1'b0);

        // Increment every cycle with the consumer always ready: handshake and
        // increment coincide on the same edge.
        hold(1, to_gray(8'd1), 1'b1);
        for (int b = 2; b < 10; b++) hold(1, to_gray(W'(b)), 1'b1);
        hold(5, to_gray(8'd9), 1'b1);

        // Saturation with no consumer, then functional init clears everything.
        cnt = 8'd9;
        for (int i = 0; i < 40; i++) begin
            cnt = cnt + 8'd100;
            hold(1, to_gray(cnt), 1'b0);
        end
        hold(4, to_gray(cnt), 1'b0);
        step(1'b1, 1'b0, to_gray(cnt), 1'b0);
        hold(5, to_gray(cnt), 1'b1);

        // Two-bit gray jump 00 -> 03 after reset.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        hold(6, 8'h00, 1'b0);
        hold(6, 8'h03, 1'b0);

        // Randomized traffic: small steps, occasional glitches, resets and inits.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        cnt = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) == 0) cnt = cnt + W'($urandom_range(0, 3));
            g = to_gray(cnt);
            if ($urandom_range(0, 63) == 0) g = W'($urandom);
            rdy  = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 299) != 0);
            init = ($urandom_range(0, 199) != 0);
            step(rst, init, g, rdy);
        end

        repeat (3) @(posedge clk_d);
        #2;
        if (expq.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
